// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, single-outstanding imem requests, prefetch FIFO, redirect flush.
// Optional IFU_BYPASS_EN: a response arriving at an empty FIFO is presented to decode in the same cycle.
module instr_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [ADDR_W-1:0]             imem_req_addr,
    input  logic                          imem_rsp_valid,
    input  logic [31:0]                   imem_rsp_data,
    input  logic                          redirect_valid,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic                          id_valid,
    input  logic                          id_ready,
    output logic [31:0]                   id_instr,
    output logic [5:0]                    id_opcode,
    output logic [ADDR_W-1:0]             id_pc,
    output logic [ADDR_W-1:0]             id_pc_plus4,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx, out_addr;
    logic [LVL_W-1:0]  wr_ptr, rd_ptr, level;
    logic [31:0]       fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];
    logic              empty, accept, rsp_take, byp, push, pop;
    logic [31:0]       head_instr;
    logic [ADDR_W-1:0] head_pc;
    logic              unused_bits;

    assign unused_bits = &{1'b0, redirect_pc[1:0]};

    assign level      = wr_ptr - rd_ptr;
    assign empty      = (level == '0);
    assign fifo_level = level;

    // No request leaves while reset is held, so nothing can be accepted during reset.
    assign imem_req_valid = rst_n && (state == FETCH) && (level < DEPTH_L);
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_take       = (state == WAIT) && imem_rsp_valid;

`ifdef IFU_BYPASS_EN
    assign byp = rsp_take && empty && !redirect_valid;
`else
    assign byp = 1'b0;
`endif

    assign head_instr = fifo_instr[rd_ptr[PTR_W-1:0]];
    assign head_pc    = fifo_pc[rd_ptr[PTR_W-1:0]];

    assign id_valid    = !empty || byp;
    assign id_instr    = byp ? imem_rsp_data : (empty ? 32'h0 : head_instr);
    assign id_pc       = byp ? out_addr : (empty ? '0 : head_pc);
    assign id_opcode   = id_instr[31:26];
    assign id_pc_plus4 = id_valid ? id_pc + ADDR_W'(4) : '0;

    assign pop  = !empty && id_valid && id_ready;
    assign push = rsp_take && !redirect_valid && !(byp && id_ready);

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        case (state)
            FETCH: if (accept) begin
                state_nx = WAIT;
                pc_nx    = pc + ADDR_W'(4);
            end
            WAIT:    if (imem_rsp_valid) state_nx = FETCH;
            DRAIN:   if (imem_rsp_valid) state_nx = FETCH;
            default: state_nx = FETCH;
        endcase
        // Redirect wins; an in-flight request must still be drained before refetching.
        if (redirect_valid) begin
            pc_nx = {redirect_pc[ADDR_W-1:2], 2'b00};
            if ((state == FETCH && accept) || (state == WAIT && !imem_rsp_valid))
                state_nx = DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            out_addr <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (accept) out_addr <= pc;
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + LVL_W'(1);
                if (pop)  rd_ptr <= rd_ptr + LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr[PTR_W-1:0]] <= imem_rsp_data;
            fifo_pc[wr_ptr[PTR_W-1:0]]    <= out_addr;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: memory model + stream scoreboard plus directed boundary checks.
module tb_instr_fetch_unit;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;
`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc, id_pc_plus4;
    logic [5:0]  id_opcode;
    logic [2:0]  fifo_level;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_opcode(id_opcode),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .fifo_level(fifo_level)
    );

    int n_chk = 0, n_fail = 0, n_hs = 0;
    int rdy_pct = 100, idr_pct = 100, redir_pct = 0, min_dly = 0, max_dly = 0;
    bit force_redir = 1'b0;
    logic [31:0] force_target = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model and random stimulus driver.
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    initial begin
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) pend = 1'b0;
            else begin
                if (imem_rsp_valid) pend = 1'b0;
                if (imem_req_valid && imem_req_ready) begin
                    pend      = 1'b1;
                    pend_addr = imem_req_addr;
                    pend_cnt  = $urandom_range(max_dly, min_dly);
                end
            end
            @(posedge clk); #1;
            imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
            id_ready       = ($urandom_range(99, 0) < idr_pct);
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (pend && rst_n) begin
                if (pend_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr);
                end else pend_cnt--;
            end
            redirect_pc = $urandom;
            if (force_redir) begin
                redirect_valid = 1'b1;
                redirect_pc    = force_target;
                force_redir    = 1'b0;
            end else redirect_valid = rst_n && ($urandom_range(99, 0) < redir_pct);
        end
    end

    // Scoreboard monitor: expected stream is sequential PCs restarted by reset or redirect.
    logic [31:0] exp_q[$];
    logic [31:0] h, w;
    bit          pv_hold = 1'b0;
    logic [31:0] pv_addr = '0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            exp_q.push_back(RST_PC);
            pv_hold = 1'b0;
        end else begin
            if (pv_hold) begin
                check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
                check("req_hold_addr", imem_req_addr, pv_addr);
            end
            check("level_bound", {31'b0, fifo_level <= 3'(DEPTH)}, 32'd1);
            if (id_valid && id_ready) begin
                h = exp_q.pop_front();
                if (exp_q.size() == 0) exp_q.push_back(h + 32'd4);
                w = mem_word(h);
                n_hs++;
                check("id_pc", id_pc, h);
                check("id_instr", id_instr, w);
                check("id_opcode", {26'b0, id_opcode}, {26'b0, w[31:26]});
                check("id_pc_plus4", id_pc_plus4, h + 32'd4);
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_q.push_back(redirect_pc & ~32'd3);
            end
            pv_hold = imem_req_valid && !imem_req_ready && !redirect_valid;
            pv_addr = imem_req_addr;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_pc_plus4", id_pc_plus4, 32'd0);
        check("rst_level", {29'b0, fifo_level}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    int t;
    initial begin
        // Response latency to decode with an empty FIFO.
        rdy_pct = 100; idr_pct = 100; redir_pct = 0; min_dly = 0; max_dly = 0;
        do_reset();
        t = 0;
        @(negedge clk);
        while (!imem_rsp_valid && t < 20) begin @(negedge clk); t++; end
        check("byp_rsp_seen", {31'b0, imem_rsp_valid}, 32'd1);
        check("byp_same_cycle_valid", {31'b0, id_valid}, {31'b0, BYP});
        @(negedge clk);
        if (BYP) check("byp_level_next", {29'b0, fifo_level}, 32'd0);
        else begin
            check("nobyp_valid_next", {31'b0, id_valid}, 32'd1);
            check("nobyp_level_next", {29'b0, fifo_level}, 32'd1);
        end

        // FIFO fills, request stalls, one pop reopens fetching at the next address.
        idr_pct = 0;
        do_reset();
        t = 0;
        @(negedge clk);
        while (fifo_level != 3'(DEPTH) && t < 60) begin @(negedge clk); t++; end
        check("full_level", {29'b0, fifo_level}, DEPTH);
        check("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("full_head_pc", id_pc, RST_PC);
        idr_pct = 100;
        @(negedge clk);
        idr_pct = 0;
        @(negedge clk);
        check("pop_level", {29'b0, fifo_level}, DEPTH - 1);
        check("pop_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("pop_req_addr", imem_req_addr, RST_PC + 32'h10);

        // Redirect while a response is outstanding: stale response dropped.
        idr_pct = 100; min_dly = 1; max_dly = 1;
        do_reset();
        t = 0;
        @(negedge clk);
        while (!(imem_req_valid && imem_req_ready) && t < 20) begin @(negedge clk); t++; end
        force_target = 32'h103;
        force_redir  = 1'b1;
        @(negedge clk);
        check("redir_applied", {31'b0, redirect_valid}, 32'd1);
        t = 0;
        while (!imem_req_valid && t < 20) begin @(negedge clk); t++; end
        check("redir_req_addr", imem_req_addr, 32'h100);
        t = 0;
        while (!id_valid && t < 20) begin @(negedge clk); t++; end
        check("redir_first_id_pc", id_pc, 32'h100);

        // Address wrap at the top of the address space.
        min_dly = 0; max_dly = 2;
        force_target = 32'hFFFF_FFF9;
        force_redir  = 1'b1;
        @(negedge clk);
        t = 0;
        while (!(id_valid && id_pc == 32'hFFFF_FFFC) && t < 40) begin @(negedge clk); t++; end
        check("wrap_seen_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", id_pc_plus4, 32'h0);
        repeat (20) @(negedge clk);

        // Randomized traffic, with a reset in the middle.
        for (int i = 0; i < 20; i++) begin
            rdy_pct   = $urandom_range(100, 30);
            idr_pct   = $urandom_range(100, 0);
            redir_pct = $urandom_range(8, 0);
            min_dly   = 0;
            max_dly   = $urandom_range(3, 0);
            if (i == 10) do_reset();
            repeat (200) @(negedge clk);
        end
        check("progress", {31'b0, n_hs > 200}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
